// File: rtl/index_register_file_banked.sv
// Clocked index register file with bank-switched low registers, pair transfers
// and INC zero/carry flags, driving a shared tri-state data bus.
module index_register_file_banked #(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned BANKS       = 2,
    parameter int unsigned BANKED_REGS = 8,
    localparam int unsigned ADDR_W     = $clog2(DEPTH),
    localparam int unsigned BANK_W     = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        index_register_op,
    input  logic [ADDR_W-1:0] index_register_select,
    input  logic [BANK_W-1:0] index_register_bank,
    inout  wire  [DATA_W-1:0] data_bus,
    output logic              bus_drive,
    output logic              busy,
    output logic              zero_flag,
    output logic              carry_flag
);
    localparam int unsigned PHYS   = DEPTH + (BANKS - 1) * BANKED_REGS;
    localparam int unsigned PHYS_W = (PHYS > 1) ? $clog2(PHYS) : 1;

    localparam logic [2:0] OP_WRITE      = 3'b001;
    localparam logic [2:0] OP_READ       = 3'b010;
    localparam logic [2:0] OP_INC        = 3'b011;
    localparam logic [2:0] OP_WRITE_PAIR = 3'b100;
    localparam logic [2:0] OP_READ_PAIR  = 3'b101;

    typedef enum logic [1:0] {IDLE, WR2, RD2} state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [PHYS];
    logic [DATA_W-1:0]   rd_latch;
    logic [PHYS_W-1:0]   pair_addr;
    logic [BANK_W-1:0]   bank_eff;
    logic [ADDR_W-1:0]   sel_even;
    logic [ADDR_W-1:0]   sel_odd;
    logic [PHYS_W-1:0]   addr;
    logic [PHYS_W-1:0]   addr_even;
    logic [PHYS_W-1:0]   addr_odd;
    logic [DATA_W-1:0]   cur_val;
    logic [DATA_W-1:0]   inc_val;

    // Bank 0 and shared words sit at their index; extra banks follow DEPTH.
    function automatic logic [PHYS_W-1:0] phys(input logic [BANK_W-1:0] b,
                                               input logic [ADDR_W-1:0] idx);
        int unsigned i;
        int unsigned bk;
        i  = 32'(idx);
        bk = 32'(b);
        if (i < BANKED_REGS && bk != 0)
            return PHYS_W'(DEPTH + (bk - 1) * BANKED_REGS + i);
        return PHYS_W'(i);
    endfunction

    assign bank_eff  = (32'(index_register_bank) < BANKS) ? index_register_bank : '0;
    assign sel_even  = index_register_select & ~ADDR_W'(1);
    assign sel_odd   = sel_even | ADDR_W'(1);
    assign addr      = phys(bank_eff, index_register_select);
    assign addr_even = phys(bank_eff, sel_even);
    assign addr_odd  = phys(bank_eff, sel_odd);
    assign cur_val   = mem[addr];
    assign inc_val   = cur_val + DATA_W'(1);

    assign data_bus  = bus_drive ? rd_latch : 'z;

    // Op acceptance, storage update and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(PHYS); i++) mem[i] <= '0;
            state      <= IDLE;
            rd_latch   <= '0;
            pair_addr  <= '0;
            bus_drive  <= 1'b0;
            busy       <= 1'b0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
        end else begin
            bus_drive <= 1'b0;
            busy      <= 1'b0;
            case (state)
                IDLE: begin
                    case (index_register_op)
                        OP_WRITE: mem[addr] <= data_bus;
                        OP_READ: begin
                            rd_latch  <= cur_val;
                            bus_drive <= 1'b1;
                        end
                        OP_INC: begin
                            mem[addr]  <= inc_val;
                            zero_flag  <= (inc_val == '0);
                            carry_flag <= &cur_val;
                        end
                        OP_WRITE_PAIR: begin
                            mem[addr_even] <= data_bus;
                            pair_addr      <= addr_odd;
                            state          <= WR2;
                            busy           <= 1'b1;
                        end
                        OP_READ_PAIR: begin
                            rd_latch  <= mem[addr_even];
                            bus_drive <= 1'b1;
                            pair_addr <= addr_odd;
                            state     <= RD2;
                            busy      <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                WR2: begin
                    mem[pair_addr] <= data_bus;
                    state          <= IDLE;
                end
                RD2: begin
                    rd_latch  <= mem[pair_addr];
                    bus_drive <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_index_register_file_banked.sv
// Directed, table-driven bench for index_register_file_banked (default parameters).
module tb_index_register_file_banked;
    localparam logic [2:0] NOP = 3'd0, WR = 3'd1, RD = 3'd2, INC = 3'd3,
                           WP = 3'd4, RP = 3'd5, R6 = 3'd6, R7 = 3'd7;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] op;
    logic [3:0] sel;
    logic       bank;
    logic       tb_drv;
    logic [3:0] tb_val;
    wire  [3:0] data_bus;
    logic       bus_drive, busy, zero_flag, carry_flag;
    int         n_vec = 0;
    int         n_bad = 0;

    assign data_bus = tb_drv ? tb_val : 'z;
    always #5 clk = ~clk;

    index_register_file_banked dut (
        .clk                  (clk),
        .reset                (reset),
        .index_register_op    (op),
        .index_register_select(sel),
        .index_register_bank  (bank),
        .data_bus             (data_bus),
        .bus_drive            (bus_drive),
        .busy                 (busy),
        .zero_flag            (zero_flag),
        .carry_flag           (carry_flag)
    );

    typedef struct {
        logic [2:0] op;
        logic [3:0] sel;
        logic       bank;
        logic       drv;
        logic [3:0] din;
        logic       e_drive;
        logic [3:0] e_bus;
        logic       e_busy;
        logic       e_z;
        logic       e_c;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [2:0] o, logic [3:0] s, logic b, logic d,
                                logic [3:0] di, logic ed, logic [3:0] eb,
                                logic ebusy, logic ez, logic ec);
        vec_t v;
        v.op = o; v.sel = s; v.bank = b; v.drv = d; v.din = di;
        v.e_drive = ed; v.e_bus = eb; v.e_busy = ebusy; v.e_z = ez; v.e_c = ec;
        return v;
    endfunction

    task automatic put(logic [2:0] o, logic [3:0] s, logic b, logic d, logic [3:0] di);
        op = o; sel = s; bank = b; tb_drv = d; tb_val = di;
    endtask

    // Clock edge, release our bus drive, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1 tb_drv = 1'b0;
        #1;
    endtask

    task automatic chk(string name, logic ed, logic [3:0] eb, logic ebusy,
                       logic ez, logic ec);
        logic ok;
        n_vec++;
        ok = (bus_drive === ed) && (busy === ebusy) && (zero_flag === ez) &&
             (carry_flag === ec) && (!ed || data_bus === eb);
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got drive=%b bus=%h busy=%b z=%b c=%b, want drive=%b bus=%h busy=%b z=%b c=%b",
                     name, bus_drive, data_bus, busy, zero_flag, carry_flag,
                     ed, eb, ebusy, ez, ec);
        end
    endtask

    initial begin
        // op, sel, bank, tb_drv, din | drive, bus, busy, z, c
        vecs.push_back(mk(RD,  4'd5, 0, 0, 4'h0, 1, 4'h0, 0, 0, 0));
        vecs.push_back(mk(NOP, 4'd0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0));
        vecs.push_back(mk(WR,  4'd3, 0, 1, 4'hA, 0, 4'h0, 0, 0, 0));
        vecs.push_back(mk(RD,  4'd3, 0, 0, 4'h0, 1, 4'hA, 0, 0, 0));
        vecs.push_back(mk(NOP, 4'd0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0));
        vecs.push_back(mk(RD,  4'd3, 0, 0, 4'h0, 1, 4'hA, 0, 0, 0));
        vecs.push_back(mk(RD,  4'd0, 0, 0, 4'h0, 1, 4'h0, 0, 0, 0));
        vecs.push_back(mk(NOP, 4'd0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0));
        vecs.push_back(mk(WP,  4'd5, 0, 1, 4'h7, 0, 4'h0, 1, 0, 0));
        vecs.push_back(mk(WR,  4'd9, 0, 1, 4'hC, 0, 4'h0, 0, 0, 0));
        vecs.push_back(mk(RD,  4'd9, 0, 0, 4'h0, 1, 4'h0, 0, 0, 0));
        vecs.push_back(mk(RP,  4'd4, 0, 0, 4'h0, 1, 4'h7, 1, 0, 0));
        vecs.push_back(mk(NOP, 4'd0, 0, 0, 4'h0, 1, 4'hC, 0, 0, 0));
        vecs.push_back(mk(NOP, 4'd0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0));
        vecs.push_back(mk(RP,  4'd5, 0, 0, 4'h0, 1, 4'h7, 1, 0, 0));
        vecs.push_back(mk(RD,  4'd0, 0, 0, 4'h0, 1, 4'hC, 0, 0, 0));
        vecs.push_back(mk(NOP, 4'd0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0));
        vecs.push_back(mk(WR,  4'd2, 0, 1, 4'hF, 0, 4'h0, 0, 0, 0));
        vecs.push_back(mk(INC, 4'd2, 0, 0, 4'h0, 0, 4'h0, 0, 1, 1));
        vecs.push_back(mk(RD,  4'd2, 0, 0, 4'h0, 1, 4'h0, 0, 1, 1));
        vecs.push_back(mk(INC, 4'd2, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0));
        vecs.push_back(mk(RD,  4'd2, 0, 0, 4'h0, 1, 4'h1, 0, 0, 0));
        vecs.push_back(mk(NOP, 4'd0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0));
        vecs.push_back(mk(WR,  4'd1, 0, 1, 4'hF, 0, 4'h0, 0, 0, 0));
        vecs.push_back(mk(INC, 4'd1, 0, 0, 4'h0, 0, 4'h0, 0, 1, 1));
        vecs.push_back(mk(WR,  4'd1, 0, 1, 4'h5, 0, 4'h0, 0, 1, 1));
        vecs.push_back(mk(RD,  4'd1, 0, 0, 4'h0, 1, 4'h5, 0, 1, 1));
        vecs.push_back(mk(NOP, 4'd0, 0, 0, 4'h0, 0, 4'h0, 0, 1, 1));
        vecs.push_back(mk(WR,  4'd8, 0, 1, 4'hF, 0, 4'h0, 0, 1, 1));
        vecs.push_back(mk(INC, 4'd3, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0));
        vecs.push_back(mk(WP,  4'd0, 0, 1, 4'h1, 0, 4'h0, 1, 0, 0));
        vecs.push_back(mk(INC, 4'd8, 0, 1, 4'h2, 0, 4'h0, 0, 0, 0));
        vecs.push_back(mk(RD,  4'd8, 0, 0, 4'h0, 1, 4'hF, 0, 0, 0));
        vecs.push_back(mk(RD,  4'd3, 0, 0, 4'h0, 1, 4'hB, 0, 0, 0));
        vecs.push_back(mk(RD,  4'd1, 0, 0, 4'h0, 1, 4'h2, 0, 0, 0));
        vecs.push_back(mk(RD,  4'd0, 0, 0, 4'h0, 1, 4'h1, 0, 0, 0));
        vecs.push_back(mk(NOP, 4'd0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0));
        vecs.push_back(mk(WR,  4'd2, 0, 1, 4'h5, 0, 4'h0, 0, 0, 0));
        vecs.push_back(mk(WR,  4'd2, 1, 1, 4'h9, 0, 4'h0, 0, 0, 0));
        vecs.push_back(mk(RD,  4'd2, 0, 0, 4'h0, 1, 4'h5, 0, 0, 0));
        vecs.push_back(mk(RD,  4'd2, 1, 0, 4'h0, 1, 4'h9, 0, 0, 0));
        vecs.push_back(mk(NOP, 4'd0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0));
        vecs.push_back(mk(WR,  4'd10, 0, 1, 4'h3, 0, 4'h0, 0, 0, 0));
        vecs.push_back(mk(RD,  4'd10, 1, 0, 4'h0, 1, 4'h3, 0, 0, 0));
        vecs.push_back(mk(RD,  4'd3, 1, 0, 4'h0, 1, 4'h0, 0, 0, 0));
        vecs.push_back(mk(RD,  4'd0, 1, 0, 4'h0, 1, 4'h0, 0, 0, 0));
        vecs.push_back(mk(NOP, 4'd0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0));
        vecs.push_back(mk(R6,  4'd2, 0, 1, 4'hE, 0, 4'h0, 0, 0, 0));
        vecs.push_back(mk(R7,  4'd2, 0, 1, 4'hD, 0, 4'h0, 0, 0, 0));
        vecs.push_back(mk(RD,  4'd2, 0, 0, 4'h0, 1, 4'h5, 0, 0, 0));
        vecs.push_back(mk(NOP, 4'd0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0));

        put(NOP, 4'd0, 1'b0, 1'b0, 4'h0);
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 chk("reset_state", 0, 4'h0, 0, 0, 0);
        @(posedge clk);
        #2 reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            put(vecs[i].op, vecs[i].sel, vecs[i].bank, vecs[i].drv, vecs[i].din);
            step();
            chk($sformatf("vec%0d", i), vecs[i].e_drive, vecs[i].e_bus,
                vecs[i].e_busy, vecs[i].e_z, vecs[i].e_c);
        end

        // Set flags, then abort a WRITE_PAIR with an asynchronous reset in WR2.
        put(INC, 4'd8, 1'b0, 1'b0, 4'h0); step();
        chk("flags_pre_reset", 0, 4'h0, 0, 1, 1);
        put(WP, 4'd6, 1'b0, 1'b1, 4'h8); step();
        chk("wp6_busy", 0, 4'h0, 1, 1, 1);
        put(WR, 4'd9, 1'b0, 1'b1, 4'h4);
        reset = 1'b0;
        #1 chk("reset_in_wr2", 0, 4'h0, 0, 0, 0);
        put(NOP, 4'd0, 1'b0, 1'b0, 4'h0);
        @(posedge clk);
        #2 reset = 1'b1;
        put(RD, 4'd6, 1'b0, 1'b0, 4'h0); step();
        chk("rd6_after_abort", 1, 4'h0, 0, 0, 0);
        put(RD, 4'd7, 1'b0, 1'b0, 4'h0); step();
        chk("rd7_after_abort", 1, 4'h0, 0, 0, 0);
        put(RD, 4'd2, 1'b0, 1'b0, 4'h0); step();
        chk("rd2_cleared", 1, 4'h0, 0, 0, 0);
        put(NOP, 4'd0, 1'b0, 1'b0, 4'h0); step();
        chk("idle_after_abort", 0, 4'h0, 0, 0, 0);
        put(WR, 4'd7, 1'b0, 1'b1, 4'h4); step();
        chk("wr7_accepted", 0, 4'h0, 0, 0, 0);
        put(RD, 4'd7, 1'b0, 1'b0, 4'h0); step();
        chk("rd7_new", 1, 4'h4, 0, 0, 0);

        // Abort a READ_PAIR in RD2: drive drops at once, no second beat.
        put(RP, 4'd6, 1'b0, 1'b0, 4'h0); step();
        chk("rp6_first", 1, 4'h0, 1, 0, 0);
        put(NOP, 4'd0, 1'b0, 1'b0, 4'h0);
        reset = 1'b0;
        #1 chk("reset_in_rd2", 0, 4'h0, 0, 0, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        step();
        chk("idle_after_rd_abort", 0, 4'h0, 0, 0, 0);
        put(RD, 4'd7, 1'b0, 1'b0, 4'h0); step();
        chk("rd7_after_rd_abort", 1, 4'h0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/index_register_file_banked.md
Name: index_register_file_banked

Overview:
- Parametrised successor to the 16x4 index register file for the 4004/4040-class datapath.
- Adds a clock and synchronous ops, register-pair transfers, and increment with zero/carry flags (for INC/ISZ).
- Adds 4040-style bank switching of the low registers.
- Sits between the instruction decoder and the shared tri-state data bus.

Parameters:
- DATA_W, 4, width of each register and of data_bus.
- DEPTH, 16, architectural registers per bank view. Must be even and at least 2.
- BANKS, 2, number of banks for the banked region. Must be at least 1.
- BANKED_REGS, 8, registers with index < BANKED_REGS are banked; the rest are shared. Must be even and no greater than DEPTH.
- Derived: ADDR_W = clog2(DEPTH), BANK_W = max(1, clog2(BANKS)).
- Physical storage is DEPTH + (BANKS-1)*BANKED_REGS words.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- index_register_op  in  3  operation code, sampled on the rising edge when busy=0.
- index_register_select  in  ADDR_W  register index. Pair ops use the even pair base (select with LSB forced to 0).
- index_register_bank  in  BANK_W  bank select, sampled with op. A value >= BANKS is treated as bank 0.
- data_bus  inout  DATA_W  shared tri-state bus. Driven only while bus_drive=1, otherwise 'z.
- bus_drive  out  1  registered; high in each cycle the block drives data_bus.
- busy  out  1  registered; high during the second cycle of a pair op.
- zero_flag  out  1  registered; result==0 of the last INC.
- carry_flag  out  1  registered; overflow of the last INC.

Behaviour:
- Op codes:
  - 000 NOP.
  - 001 WRITE.
  - 010 READ.
  - 011 INC.
  - 100 WRITE_PAIR.
  - 101 READ_PAIR.
  - 110 and 111 are reserved and act as NOP.
- Reset (reset=0, asynchronous):
  - All physical registers are cleared to 0. There is no preload pattern in this generation.
  - FSM goes to IDLE.
  - bus_drive=0, busy=0, zero_flag=0, carry_flag=0, output latch=0.
  - data_bus is released immediately.
- Address map: for index < BANKED_REGS, the physical word is chosen by (bank, index). For other indices, the word is shared by all banks.
- FSM states: IDLE, WR2, RD2. busy=1 exactly when the state is WR2 or RD2.
- IDLE, WRITE: at the edge, reg[bank,sel] <= data_bus. No drive. Stay in IDLE.
- IDLE, READ:
  - At the edge, latch <= reg[bank,sel] and bus_drive <= 1.
  - The bus carries the value for exactly the next cycle, then bus_drive=0 unless a new READ was accepted.
  - Back-to-back READs keep bus_drive high continuously.
- IDLE, INC:
  - At the edge, reg <= (reg+1) mod 2^DATA_W.
  - zero_flag <= (result==0).
  - carry_flag <= (old value == all ones).
  - Flags hold their value until the next INC. No other op changes them.
- IDLE, WRITE_PAIR:
  - At the edge, reg[even] <= data_bus (high nibble). Bank and pair base are latched. Go to WR2.
  - WR2: at the next edge, reg[even+1] <= data_bus (low nibble). Go to IDLE.
- IDLE, READ_PAIR:
  - At the edge, latch <= reg[even] and bus_drive <= 1. Go to RD2.
  - RD2: at the next edge, latch <= reg[even+1] and bus_drive stays 1. Go to IDLE.
  - The bus shows even then odd in two consecutive cycles.
- Ops presented while busy=1 are ignored entirely: no write, no flag change, no queueing.
- Odd select on a pair op is silently aligned down to the even register.
- Read values reflect storage before the accepting edge. Same-edge read-after-write does not bypass.
- Reset asserted in WR2 or RD2 aborts the op. The odd register is not written, drive is released, and the FSM is in IDLE after release.
- With BANKS=1, index_register_bank is ignored.

Test Plan:
- Reset then READ sel=5 -> next cycle data_bus=0x0 with bus_drive=1, then 'z. zero_flag=0, carry_flag=0.
- WRITE sel=3, bus=0xA; READ sel=3 -> bus=0xA for exactly one cycle. Back-to-back READ sel=3, READ sel=0 -> 0xA then 0x0 with bus_drive held high.
- WRITE_PAIR sel=5 with bus 0x7 then 0xC -> reg4=0x7, reg5=0xC, busy high for one cycle. WRITE sel=9 issued during busy -> reg9 unchanged. READ_PAIR sel=4 -> bus 0x7 then 0xC on consecutive cycles.
- WRITE reg2=0xF; INC sel=2 -> reg2=0x0, zero=1, carry=1. INC again -> 0x1, zero=0, carry=0. Subsequent WRITE leaves flags unchanged.
- Bank 0 WRITE reg2=0x5, bank 1 WRITE reg2=0x9 -> READs return 0x5 and 0x9 respectively. Bank 0 WRITE reg10=0x3; bank 1 READ reg10 -> 0x3.
- WRITE_PAIR sel=6, assert reset during WR2 -> reg6=0, reg7=0, busy=0, bus 'z; first op after release is accepted normally.
